rst_cipher_ctrl: RTL and testbench

- Sequencer for the RST cipher datapath: collects a 12-character key serially, validates it, and loads the 7x7 rotation-table block.
- Once the table is configured, streams plaintext characters and emits two ciphertext bytes per character: row header, then column header.
- Sits between the host byte stream and the rotation-table block. Owns key lifecycle, error reporting and rekey.

---
 rtl/rst_cipher_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_rst_cipher_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_cipher_ctrl.sv
// RST cipher sequencer: serial key capture and validation, rotation-table load,
// then per-character plaintext to (row header, column header) ciphertext pairs.
module rst_cipher_ctrl #(
    parameter int KEY_LEN = 12,
    parameter int TBL_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_valid,
    input  logic [7:0]           key_char,
    output logic                 key_ready,
    input  logic                 rekey,
    output logic [8*KEY_LEN-1:0] tbl_key,
    output logic                 tbl_load,
    input  logic                 pt_valid,
    input  logic [7:0]           pt_char,
    output logic                 pt_ready,
    output logic                 ct_valid,
    output logic [7:0]           ct_char,
    input  logic                 ct_ready,
    output logic                 busy,
    output logic                 key_ok,
    output logic                 err_repeated_char,
    output logic                 err_invalid_key_char,
    output logic                 err_invalid_pt
);

    typedef enum logic [2:0] {S_LOAD, S_CFG, S_WAIT, S_RUN, S_ERR} state_t;
    typedef enum logic [1:0] {O_IDLE, O_HI, O_LO} ostage_t;

    localparam logic [3:0] KEY_LAST  = 4'(KEY_LEN - 1);
    localparam logic [3:0] WAIT_LAST = 4'(TBL_LAT - 1);

    state_t                    state, state_nx;
    ostage_t                   ostage;
    logic [KEY_LEN-1:0][7:0]   key_q;
    logic [3:0]                cnt;
    logic [3:0]                wait_cnt;
    logic [7:0]                col_byte;

    logic       key_acc, last_key, dup, key_bad;
    logic       err_rep_nx, err_inv_nx;
    logic       pt_acc, pt_ok, pt_alpha, pt_digit;
    logic [7:0] pt_lc;
    logic [5:0] pt_k;
    logic [2:0] pt_row, pt_col;
    logic [7:0] row_sel, col_sel;

    function automatic logic is_alnum(input logic [7:0] c);
        return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A) ||
               (c >= 8'h30 && c <= 8'h39);
    endfunction

    // Header layout interleaves row and column headers through the key.
    function automatic logic [3:0] row_key_idx(input logic [2:0] r);
        case (r)
            3'd0:    return 4'd0;
            3'd1:    return 4'd10;
            3'd2:    return 4'd2;
            3'd3:    return 4'd8;
            3'd4:    return 4'd4;
            default: return 4'd6;
        endcase
    endfunction

    function automatic logic [3:0] col_key_idx(input logic [2:0] c);
        case (c)
            3'd0:    return 4'd1;
            3'd1:    return 4'd11;
            3'd2:    return 4'd3;
            3'd3:    return 4'd9;
            3'd4:    return 4'd5;
            default: return 4'd7;
        endcase
    endfunction

    assign tbl_key   = key_q;
    assign key_ready = (state == S_LOAD);
    assign key_ok    = (state == S_RUN);
    assign busy      = !((state == S_RUN) && (ostage == O_IDLE));
    // A new character may enter in the same cycle the LO byte drains.
    assign pt_ready  = (state == S_RUN) &&
                       ((ostage == O_IDLE) || ((ostage == O_LO) && ct_ready));

    assign key_acc    = key_valid && key_ready && !rekey;
    assign last_key   = key_acc && (cnt == KEY_LAST);
    assign key_bad    = !is_alnum(key_char);
    assign err_rep_nx = err_repeated_char || (key_acc && dup);
    assign err_inv_nx = err_invalid_key_char || (key_acc && key_bad);
    assign pt_acc     = pt_valid && pt_ready && !rekey;

    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < KEY_LEN; i++)
            if (4'(i) < cnt && key_q[i] == key_char) dup = 1'b1;
    end

    always_comb begin
        pt_lc = pt_char;
        if (pt_char >= 8'h41 && pt_char <= 8'h5A) pt_lc = pt_char | 8'h20;
        pt_alpha = (pt_lc >= 8'h61 && pt_lc <= 8'h7A);
        pt_digit = (pt_lc >= 8'h30 && pt_lc <= 8'h39);
        pt_ok    = pt_alpha || pt_digit;
        pt_k     = 6'd0;
        if (pt_alpha)      pt_k = 6'(pt_lc - 8'h61);
        else if (pt_digit) pt_k = 6'(pt_lc - 8'h30) + 6'd26;
        pt_row  = 3'(pt_k / 6'd6);
        pt_col  = 3'(pt_k % 6'd6);
        row_sel = key_q[row_key_idx(pt_row)];
        col_sel = key_q[col_key_idx(pt_col)];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_LOAD;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_LOAD: if (last_key) state_nx = (err_rep_nx || err_inv_nx) ? S_ERR : S_CFG;
            S_CFG:  state_nx = S_WAIT;
            S_WAIT: if (wait_cnt == WAIT_LAST) state_nx = S_RUN;
            default: state_nx = state;
        endcase
        if (rekey) state_nx = S_LOAD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q                <= '0;
            cnt                  <= 4'd0;
            wait_cnt             <= 4'd0;
            tbl_load             <= 1'b0;
            ostage               <= O_IDLE;
            ct_valid             <= 1'b0;
            ct_char              <= 8'h00;
            col_byte             <= 8'h00;
            err_repeated_char    <= 1'b0;
            err_invalid_key_char <= 1'b0;
            err_invalid_pt       <= 1'b0;
        end else begin
            tbl_load <= (state == S_CFG) && !rekey;
            if (rekey) begin
                // Key bytes are kept; only lifecycle and output state restart.
                cnt                  <= 4'd0;
                wait_cnt             <= 4'd0;
                ostage               <= O_IDLE;
                ct_valid             <= 1'b0;
                err_repeated_char    <= 1'b0;
                err_invalid_key_char <= 1'b0;
                err_invalid_pt       <= 1'b0;
            end else begin
                if (key_acc) begin
                    key_q[cnt]           <= key_char;
                    cnt                  <= cnt + 4'd1;
                    err_repeated_char    <= err_rep_nx;
                    err_invalid_key_char <= err_inv_nx;
                end
                wait_cnt <= (state == S_WAIT) ? wait_cnt + 4'd1 : 4'd0;
                case (ostage)
                    O_HI: if (ct_ready) begin
                        ct_char <= col_byte;
                        ostage  <= O_LO;
                    end
                    O_LO: if (ct_ready) begin
                        ct_valid <= 1'b0;
                        ostage   <= O_IDLE;
                    end
                    default: ;
                endcase
                if (pt_acc) begin
                    if (pt_ok) begin
                        ct_char  <= row_sel;
                        col_byte <= col_sel;
                        ct_valid <= 1'b1;
                        ostage   <= O_HI;
                    end else begin
                        err_invalid_pt <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rst_cipher_ctrl.sv
// Bench for rst_cipher_ctrl: transaction-level model (phase + expected ct byte queue)
// compared every cycle, plus literal expectations for the documented scenarios.
module tb_rst_cipher_ctrl;
    localparam int TBL_LAT = 1;
    localparam int M_LOAD = 0, M_CFG = 1, M_WAIT = 2, M_RUN = 3, M_ERR = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, key_valid = 1'b0, rekey = 1'b0, pt_valid = 1'b0;
    logic [7:0]  key_char = 8'h00, pt_char = 8'h00;
    logic        ct_ready;
    logic        key_ready, tbl_load, pt_ready, ct_valid, busy, key_ok;
    logic        err_repeated_char, err_invalid_key_char, err_invalid_pt;
    logic [95:0] tbl_key;
    logic [7:0]  ct_char;

    int   ct_mode = 0;
    logic ct_manual = 1'b0;

    rst_cipher_ctrl #(.KEY_LEN(12), .TBL_LAT(TBL_LAT)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_char(key_char),
        .key_ready(key_ready), .rekey(rekey), .tbl_key(tbl_key), .tbl_load(tbl_load),
        .pt_valid(pt_valid), .pt_char(pt_char), .pt_ready(pt_ready),
        .ct_valid(ct_valid), .ct_char(ct_char), .ct_ready(ct_ready),
        .busy(busy), .key_ok(key_ok), .err_repeated_char(err_repeated_char),
        .err_invalid_key_char(err_invalid_key_char), .err_invalid_pt(err_invalid_pt)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    int         m_phase = M_LOAD, m_cnt = 0, m_wait = 0;
    logic [7:0] m_key [12];
    bit         m_rep, m_inv, m_pt, m_tload, m_init = 0, m_prdy;
    logic [7:0] m_q [$];
    int         rtab [6] = '{0, 10, 2, 8, 4, 6};
    int         ctab [6] = '{1, 11, 3, 9, 5, 7};

    function automatic bit is_alnum(input logic [7:0] c);
        return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z") || (c >= "0" && c <= "9");
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_init = 1; m_phase = M_LOAD; m_cnt = 0; m_wait = 0;
            foreach (m_key[i]) m_key[i] = 8'h00;
            m_rep = 0; m_inv = 0; m_pt = 0; m_tload = 0; m_q.delete();
        end else if (m_init) begin
            m_tload = 0;
            if (rekey) begin
                m_phase = M_LOAD; m_cnt = 0; m_rep = 0; m_inv = 0; m_pt = 0; m_q.delete();
            end else begin
                case (m_phase)
                    M_LOAD: if (key_valid) begin
                        if (!is_alnum(key_char)) m_inv = 1;
                        for (int j = 0; j < m_cnt; j++) if (m_key[j] == key_char) m_rep = 1;
                        m_key[m_cnt] = key_char;
                        m_cnt++;
                        if (m_cnt == 12) m_phase = (m_rep || m_inv) ? M_ERR : M_CFG;
                    end
                    M_CFG: begin m_tload = 1; m_phase = M_WAIT; m_wait = 0; end
                    M_WAIT: begin m_wait++; if (m_wait == TBL_LAT) m_phase = M_RUN; end
                    M_RUN: begin
                        m_prdy = (m_q.size() == 0) || (m_q.size() == 1 && ct_ready);
                        if (m_q.size() > 0 && ct_ready) void'(m_q.pop_front());
                        if (pt_valid && m_prdy) begin
                            int c, k;
                            c = int'(pt_char);
                            if (c >= "A" && c <= "Z") c = c + 32;
                            if (c >= "a" && c <= "z") k = c - "a";
                            else if (c >= "0" && c <= "9") k = c - "0" + 26;
                            else k = -1;
                            if (k < 0) m_pt = 1;
                            else begin
                                m_q.push_back(m_key[rtab[k / 6]]);
                                m_q.push_back(m_key[ctab[k % 6]]);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare + ct capture ----------------
    logic [7:0] rec [$];
    int         n_tload = 0;

    always @(negedge clk) begin
        if (m_init && !rst) begin
            logic [95:0] ek;
            for (int i = 0; i < 12; i++) ek[8*i +: 8] = m_key[i];
            chk("key_ready", key_ready, m_phase == M_LOAD);
            chk("key_ok", key_ok, m_phase == M_RUN);
            chk("tbl_load", tbl_load, m_tload);
            chk("tbl_key", tbl_key, ek);
            chk("pt_ready", pt_ready, (m_phase == M_RUN) &&
                ((m_q.size() == 0) || (m_q.size() == 1 && ct_ready)));
            chk("ct_valid", ct_valid, m_q.size() > 0);
            if (m_q.size() > 0) chk("ct_char", ct_char, m_q[0]);
            chk("busy", busy, !(m_phase == M_RUN && m_q.size() == 0));
            chk("err_rep", err_repeated_char, m_rep);
            chk("err_inv_key", err_invalid_key_char, m_inv);
            chk("err_inv_pt", err_invalid_pt, m_pt);
            if (ct_valid && ct_ready) rec.push_back(ct_char);
            if (tbl_load) n_tload++;
        end
    end

    // ct_ready driver: 0=always ready, 1=random, 2=stalled, 3=manual
    initial begin
        ct_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            case (ct_mode)
                0: ct_ready = 1'b1;
                1: ct_ready = 1'($urandom_range(0, 1));
                2: ct_ready = 1'b0;
                default: ct_ready = ct_manual;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick; @(posedge clk); #1; endtask

    task automatic send_key(input logic [7:0] ka [12], input bit gaps);
        for (int i = 0; i < 12; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin key_valid = 1'b0; tick(); end
            key_valid = 1'b1; key_char = ka[i]; tick();
        end
        key_valid = 1'b0;
    endtask

    task automatic send_key_str(input string s);
        logic [7:0] ka [12];
        for (int i = 0; i < 12; i++) ka[i] = s[i];
        send_key(ka, 1'b0);
    endtask

    task automatic send_pt(input logic [7:0] c);
        bit ok = 0;
        pt_valid = 1'b1; pt_char = c;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk); ok = pt_ready; tick();
        end
        pt_valid = 1'b0;
        if (!ok) chk("pt_accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_for(input bit want_run);
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = want_run ? key_ok : !busy;
            tick();
        end
        if (!ok) chk(want_run ? "run_timeout" : "idle_timeout", 1'b0, 1'b1);
    endtask

    task automatic pulse_rekey; rekey = 1'b1; tick(); rekey = 1'b0; endtask

    task automatic chk_rec(input string nm, input string exp);
        chk({nm, "_len"}, rec.size(), exp.len());
        for (int i = 0; i < exp.len() && i < rec.size(); i++) chk(nm, rec[i], exp[i]);
        rec.delete();
    endtask

    string pool = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789";
    string ptpool = "aZ9#m .0zA~Qq5Bx";

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_key_ready", key_ready, 1); chk("rst_busy", busy, 1);
        chk("rst_tbl_load", tbl_load, 0);   chk("rst_ct_valid", ct_valid, 0);
        chk("rst_ct_char", ct_char, 0);     chk("rst_pt_ready", pt_ready, 0);
        chk("rst_key_ok", key_ok, 0);       chk("rst_tbl_key", tbl_key, 0);
        tick();

        // Basic key load and table strobe timing
        send_key_str("ABCDEFGHIJKL");
        @(negedge clk); chk("cfg_tbl_load", tbl_load, 0); chk("cfg_key_ready", key_ready, 0);
        tick();
        @(negedge clk); chk("pulse_tbl_load", tbl_load, 1); chk("pulse_key_ok", key_ok, 0);
        tick();
        @(negedge clk); chk("run_key_ok", key_ok, 1); chk("run_tbl_load", tbl_load, 0);
        chk("tbl_key_lo", tbl_key[7:0], 8'h41); chk("tbl_key_hi", tbl_key[95:88], 8'h4C);
        tick();

        // Stream a,h,9,Z
        rec.delete(); ct_mode = 0;
        send_pt("a"); send_pt("h"); send_pt("9"); send_pt("Z");
        wait_for(0);
        chk_rec("stream", "ABKLGHEL");

        // Backpressure on the HI byte
        ct_mode = 2;
        send_pt("a");
        pt_valid = 1'b1; pt_char = "b";
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ct_char", ct_char, 8'h41); chk("bp_ct_valid", ct_valid, 1);
            chk("bp_pt_ready", pt_ready, 0);
            tick();
        end
        pt_valid = 1'b0; ct_mode = 0;
        wait_for(0);
        chk_rec("bp", "AB");

        // Random plaintext with random backpressure
        ct_mode = 1;
        for (int i = 0; i < 40; i++) begin
            send_pt(ptpool[$urandom_range(0, ptpool.len() - 1)]);
            if ($urandom_range(0, 2) == 0) tick();
        end
        wait_for(0);

        // rekey while the LO byte is pending
        ct_mode = 3; ct_manual = 1'b1;
        send_pt("#");
        send_pt("c");
        tick();
        ct_manual = 1'b0; rekey = 1'b1;
        @(negedge clk);
        chk("lo_pending", ct_valid, 1); chk("lo_char", ct_char, 8'h44);
        chk("pre_rekey_err_pt", err_invalid_pt, 1);
        tick(); rekey = 1'b0;
        @(negedge clk);
        chk("rekey_ct_valid", ct_valid, 0); chk("rekey_key_ready", key_ready, 1);
        chk("rekey_err_pt", err_invalid_pt, 0);
        tick();
        ct_mode = 0; rec.delete();

        send_key_str("QWERTYuiop12");
        wait_for(1);
        rec.delete();
        send_pt("a"); send_pt("z"); send_pt("5");
        wait_for(0);
        chk_rec("newkey", "QWT2u2");

        // Key error cases
        pulse_rekey(); n_tload = 0;
        send_key_str("ABCDEFGHIJKA");
        @(negedge clk);
        chk("dup_err_rep", err_repeated_char, 1); chk("dup_err_inv", err_invalid_key_char, 0);
        tick();
        key_valid = 1'b1; key_char = "X"; repeat (3) tick(); key_valid = 1'b0;
        repeat (3) tick();
        chk("err_no_tbl_load", n_tload, 0);
        rekey = 1'b1; key_valid = 1'b1; key_char = "M"; tick();
        rekey = 1'b0; key_valid = 1'b0;
        send_key_str("AB#DEFGHIJKL");
        @(negedge clk);
        chk("inv_err_inv", err_invalid_key_char, 1); chk("inv_err_rep", err_repeated_char, 0);
        tick();

        // rst during WAIT
        pulse_rekey();
        send_key_str("ABCDEFGHIJKL");
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        chk("wrst_key_ready", key_ready, 1); chk("wrst_busy", busy, 1);
        chk("wrst_tbl_load", tbl_load, 0);   chk("wrst_key_ok", key_ok, 0);
        chk("wrst_ct_valid", ct_valid, 0);   chk("wrst_tbl_key", tbl_key, 0);
        tick();

        // Randomized rounds: random keys (sometimes faulty), random text, rekey mid-flight
        for (int r = 0; r < 8; r++) begin
            logic [7:0] ka [12];
            for (int i = 0; i < 12; i++) begin
                bit d;
                do begin
                    ka[i] = pool[$urandom_range(0, 61)];
                    d = 0;
                    for (int j = 0; j < i; j++) if (ka[j] == ka[i]) d = 1;
                end while (d);
            end
            case ($urandom_range(0, 3))
                0: ka[$urandom_range(1, 11)] = ka[0];
                1: ka[$urandom_range(0, 11)] = 8'($urandom_range(0, 255));
                default: ;
            endcase
            send_key(ka, 1'b1);
            repeat (3) tick();
            if (m_phase != M_ERR) begin
                wait_for(1);
                ct_mode = 1;
                for (int i = 0; i < 12; i++) send_pt(ptpool[$urandom_range(0, ptpool.len() - 1)]);
                repeat ($urandom_range(0, 2)) tick();
            end
            ct_mode = 0;
            pulse_rekey();
        end
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
